hfosc_pwr_seq: RTL and testbench
================================

// Module: hfosc_pwr_seq
// PURPOSE
// - Power sequencer that directly drives the HF oscillator's CLKHFPU/CLKHFEN inputs.
// - Runs on the always-on low-frequency clock (10 kHz LFOSC domain).
// - Powers the oscillator up, waits for it to settle, enables its output, then releases a ready flag and reset to HF logic.
// - Tears down in the reverse order, so the HF clock never glitches while HF logic is out of reset.
// PARAMETERS
// - PU_CYCLES     2   clk cycles from clkhfpu rise to clkhfen rise (>=1; 2 @10 kHz = 200 us, meets 100 us PU settle)
// - EN_CYCLES     4   clk cycles from clkhfen rise to hf_ready rise (>=1)
// - DRAIN_CYCLES  2   clk cycles from hf_ready fall to clkhfen fall (>=1)
// - CNT_W         4   timer width; every *_CYCLES value must be <= 2**CNT_W-1
// PORTS
// - clk        in   1      always-on low-frequency clock
// - rst_n      in   1      asynchronous, active-low reset
// - osc_req    in   1      level request: 1 = HF clock wanted, 0 = may power down
// - clkhfpu    out  1      to oscillator CLKHFPU (power-up)
// - clkhfen    out  1      to oscillator CLKHFEN (output enable)
// - hf_ready   out  1      1 = HF clock stable and running
// - hf_rst_n   out  1      active-low reset for HF logic; equals hf_ready
// - busy       out  1      1 in any transitional state
// - state_o    out  3      current FSM state encoding, for debug
// BEHAVIOUR
// - Reset (rst_n=0, async): state OFF, timer=0, all outputs 0 (hf_rst_n=0). Reset mid-sequence drops everything at once.
// - All outputs are registered; no combinational path from osc_req to any output.
// - Timer loads on entry to each timed state, decrements every clk, and exits the state on the edge where it reads 1.
// - FSM states, encoding given as state_o:
//   OFF(0): pu=0 en=0. osc_req=1 -> PWRUP; timer=PU_CYCLES.
//   PWRUP(1): pu=1 en=0 busy=1.
//     - osc_req=0 -> OFF (pu drops next edge).
//     - Timer expires -> ENWAIT; timer=EN_CYCLES.
//   ENWAIT(2): pu=1 en=1 busy=1.
//     - osc_req=0 -> PWRDN (en drops first).
//     - Timer expires -> READY.
//   READY(3): pu=1 en=1 hf_ready=1 hf_rst_n=1. osc_req=0 -> DRAIN; timer=DRAIN_CYCLES.
//   DRAIN(4): pu=1 en=1 hf_ready=0 busy=1. Timer expires -> PWRDN. osc_req is ignored (no abort).
//   PWRDN(5): pu=1 en=0 busy=1. Lasts exactly 1 cycle -> OFF. osc_req is ignored.
// - Resulting edge timing, in clk edges:
//   - clkhfen rises PU_CYCLES after clkhfpu rises.
//   - hf_ready rises EN_CYCLES after clkhfen rises.
//   - clkhfen falls DRAIN_CYCLES after hf_ready falls.
//   - clkhfpu falls 1 cycle after clkhfen.
// - Invariants:
//   - clkhfen=1 implies clkhfpu=1.
//   - hf_ready=1 implies clkhfen=1.
//   - Unused encodings 6 and 7 recover to OFF.
// - A request reasserted during DRAIN/PWRDN is honoured from OFF, one cycle after the teardown completes.
// TESTING
// - Reset release, osc_req=0 for 10 cycles -> all outputs 0, state_o=0, busy=0.
// - Defaults, osc_req=1 at edge 0:
//   - clkhfpu=1 after edge 1, clkhfen=1 after edge 3, hf_ready=hf_rst_n=1 after edge 7.
//   - busy is high over edges 1..6.
// - From READY, osc_req=0 at edge N:
//   - hf_ready=0 after N+1, clkhfen=0 after N+3, clkhfpu=0 after N+4, state_o=0.
// - Aborts:
//   - osc_req pulse of 1 cycle in OFF -> pu high 1 cycle, back to OFF, en never rises.
//   - Drop during ENWAIT -> PWRDN, then OFF.
// - Re-request during DRAIN -> full teardown completes, then PWRUP starts the cycle after OFF.
// - rst_n=0 asynchronously in READY -> all outputs 0 without a clk edge; invariants hold every cycle across a random osc_req soak.

Source files
------------

// File: rtl/hfosc_pwr_seq.sv
// hfosc_pwr_seq: sequences HF oscillator power-up/enable/ready and reverse teardown on the LF clock
module hfosc_pwr_seq #(
  parameter int PU_CYCLES    = 2,
  parameter int EN_CYCLES    = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       osc_req,
  output logic       clkhfpu,
  output logic       clkhfen,
  output logic       hf_ready,
  output logic       hf_rst_n,
  output logic       busy,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {
    OFF    = 3'd0,
    PWRUP  = 3'd1,
    ENWAIT = 3'd2,
    READY  = 3'd3,
    DRAIN  = 3'd4,
    PWRDN  = 3'd5
  } state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic expired;
  assign expired = timer_q == CNT_W'(1);
  assign state_o = state_q;
  always_comb begin
    state_d = state_q;
    timer_d = (timer_q != '0) ? timer_q - CNT_W'(1) : timer_q;
    case (state_q)
      OFF: if (osc_req) begin
        state_d = PWRUP;
        timer_d = CNT_W'(PU_CYCLES);
      end
      PWRUP: if (!osc_req) state_d = OFF;
        else if (expired) begin
          state_d = ENWAIT;
          timer_d = CNT_W'(EN_CYCLES);
        end
      ENWAIT: if (!osc_req) state_d = PWRDN;
        else if (expired) state_d = READY;
      READY: if (!osc_req) begin
        state_d = DRAIN;
        timer_d = CNT_W'(DRAIN_CYCLES);
      end
      DRAIN: if (expired) state_d = PWRDN;
      PWRDN: state_d = OFF;
      default: begin
        state_d = OFF;
        timer_d = '0;
      end
    endcase
  end
  // outputs decoded from next state so they are registered yet change with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OFF;
      timer_q  <= '0;
      clkhfpu  <= 1'b0;
      clkhfen  <= 1'b0;
      hf_ready <= 1'b0;
      hf_rst_n <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      clkhfpu  <= state_d != OFF;
      clkhfen  <= state_d inside {ENWAIT, READY, DRAIN};
      hf_ready <= state_d == READY;
      hf_rst_n <= state_d == READY;
      busy     <= state_d inside {PWRUP, ENWAIT, DRAIN, PWRDN};
    end
  end
endmodule

// File: tb/tb_hfosc_pwr_seq.sv
// tb_hfosc_pwr_seq: table-driven and directed checks of the HF oscillator sequencer
module tb_hfosc_pwr_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic osc_req = 1'b0;
  logic clkhfpu, clkhfen, hf_ready, hf_rst_n, busy;
  logic [2:0] state_o;
  int total = 0;
  int passed = 0;
  typedef struct packed {
    logic       req;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [20];
  hfosc_pwr_seq dut (
    .clk(clk), .rst_n(rst_n), .osc_req(osc_req), .clkhfpu(clkhfpu), .clkhfen(clkhfen),
    .hf_ready(hf_ready), .hf_rst_n(hf_rst_n), .busy(busy), .state_o(state_o)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(logic r, logic pu, logic en, logic rdy, logic bsy, logic [2:0] st);
    return '{req: r, exp: {pu, en, rdy, rdy, bsy, st}};
  endfunction
  function automatic logic [7:0] outs();
    return {clkhfpu, clkhfen, hf_ready, hf_rst_n, busy, state_o};
  endfunction
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b (pu en rdy rstn busy st) expected %b", name, act, exp);
  endtask
  task automatic step(logic r);
    osc_req = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = v(1, 1, 0, 0, 1, 3'd1);
    tbl[1]  = v(1, 1, 0, 0, 1, 3'd1);
    tbl[2]  = v(1, 1, 1, 0, 1, 3'd2);
    tbl[3]  = v(1, 1, 1, 0, 1, 3'd2);
    tbl[4]  = v(1, 1, 1, 0, 1, 3'd2);
    tbl[5]  = v(1, 1, 1, 0, 1, 3'd2);
    tbl[6]  = v(1, 1, 1, 1, 0, 3'd3);
    tbl[7]  = v(1, 1, 1, 1, 0, 3'd3);
    tbl[8]  = v(0, 1, 1, 0, 1, 3'd4);
    tbl[9]  = v(1, 1, 1, 0, 1, 3'd4);
    tbl[10] = v(1, 1, 0, 0, 1, 3'd5);
    tbl[11] = v(1, 0, 0, 0, 0, 3'd0);
    tbl[12] = v(1, 1, 0, 0, 1, 3'd1);
    tbl[13] = v(0, 0, 0, 0, 0, 3'd0);
    tbl[14] = v(1, 1, 0, 0, 1, 3'd1);
    tbl[15] = v(1, 1, 0, 0, 1, 3'd1);
    tbl[16] = v(1, 1, 1, 0, 1, 3'd2);
    tbl[17] = v(0, 1, 0, 0, 1, 3'd5);
    tbl[18] = v(0, 0, 0, 0, 0, 3'd0);
    tbl[19] = v(0, 0, 0, 0, 0, 3'd0);
    #12;
    chk("in_reset", outs(), 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      chk($sformatf("idle_%0d", i), outs(), 8'd0);
    end
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].req);
      chk($sformatf("vec_%0d", i), outs(), tbl[i].exp);
    end
    for (int i = 0; i < 7; i++) step(1'b1);
    chk("reach_ready", outs(), {5'b11110, 3'd3});
    #3 rst_n = 1'b0;
    #1 chk("async_reset", outs(), 8'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)));
      total++;
      if ((!clkhfen || clkhfpu) && (!hf_ready || clkhfen) && hf_rst_n == hf_ready && state_o < 3'd6)
        passed++;
      else $display("FAIL soak_inv_%0d: got %b violates invariants", i, outs());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
